// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-file constants, types and address-hit helper
package cpu_pkg;

  localparam int DW   = 16;
  localparam int NREG = 8;
  localparam int AW   = 3;

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DW-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = '0;

  // True when an enabled access targets addr and addr is not the hardwired zero register.
  function automatic logic addr_hit(input logic en, input reg_addr_t a, input reg_addr_t addr);
    return en && (a == addr) && (addr != ZERO_REG);
  endfunction

endpackage

// File: rtl/regfile_rd_if.sv
// rtl/regfile_rd_if.sv - decode/writeback bundle for the register file read side
interface regfile_rd_if import cpu_pkg::*; ();

  logic      rd_en;
  reg_addr_t rs_addr;
  reg_addr_t rt_addr;
  reg_data_t rs_data;
  reg_data_t rt_data;
  logic      rs_busy;
  logic      rt_busy;
  logic      iss_en;
  reg_addr_t iss_addr;
  logic      wr_en;
  reg_addr_t wr_addr;
  reg_data_t wr_data;

  modport master (
    output rd_en, rs_addr, rt_addr, iss_en, iss_addr, wr_en, wr_addr, wr_data,
    input  rs_data, rt_data, rs_busy, rt_busy
  );

  modport slave (
    input  rd_en, rs_addr, rt_addr, iss_en, iss_addr, wr_en, wr_addr, wr_data,
    output rs_data, rt_data, rs_busy, rt_busy
  );

endinterface

// File: rtl/regfile_word.sv
// rtl/regfile_word.sv - one DW-bit register with load enable and synchronous reset
module regfile_word import cpu_pkg::*; (
  input  logic      CLK,
  input  logic      RST,
  input  logic      ld,
  input  reg_data_t d,
  output reg_data_t q
);

  always_ff @(posedge CLK) begin
    if (RST)
      q <= '0;
    else if (ld)
      q <= d;
  end

endmodule

// File: rtl/regfile_rd.sv
// rtl/regfile_rd.sv - 8x16 register file, two registered read ports, busy scoreboard
// REGFILE_BYPASS_EN: same-cycle write-through of writeback data/busy-clear onto read ports
module regfile_rd import cpu_pkg::*; (
  input  logic         CLK,
  input  logic         RST,
  regfile_rd_if.slave  rf
);

  reg_data_t        words [NREG];
  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  busy_nxt;
  reg_data_t        rs_data_d;
  reg_data_t        rt_data_d;
  logic             rs_busy_d;
  logic             rt_busy_d;

  assign words[0] = '0;

  for (genvar g = 1; g < NREG; g++) begin : g_word
    regfile_word u_word (
      .CLK (CLK),
      .RST (RST),
      .ld  (rf.wr_en && (rf.wr_addr == reg_addr_t'(g))),
      .d   (rf.wr_data),
      .q   (words[g])
    );
  end

  // Issue is applied after the writeback clear so a same-cycle issue wins.
  always_comb begin
    busy_nxt = busy;
    if (rf.wr_en)
      busy_nxt[rf.wr_addr] = 1'b0;
    if (rf.iss_en && (rf.iss_addr != ZERO_REG))
      busy_nxt[rf.iss_addr] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  always_comb begin
    rs_data_d = words[rf.rs_addr];
    rt_data_d = words[rf.rt_addr];
`ifdef REGFILE_BYPASS_EN
    if (addr_hit(rf.wr_en, rf.wr_addr, rf.rs_addr))
      rs_data_d = rf.wr_data;
    if (addr_hit(rf.wr_en, rf.wr_addr, rf.rt_addr))
      rt_data_d = rf.wr_data;
    rs_busy_d = busy_nxt[rf.rs_addr];
    rt_busy_d = busy_nxt[rf.rt_addr];
`else
    // Writeback clear is not visible yet; a same-cycle issue still flags the operand.
    rs_busy_d = busy[rf.rs_addr] | addr_hit(rf.iss_en, rf.iss_addr, rf.rs_addr);
    rt_busy_d = busy[rf.rt_addr] | addr_hit(rf.iss_en, rf.iss_addr, rf.rt_addr);
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rf.rs_data <= '0;
      rf.rt_data <= '0;
      rf.rs_busy <= 1'b0;
      rf.rt_busy <= 1'b0;
    end else if (rf.rd_en) begin
      rf.rs_data <= rs_data_d;
      rf.rt_data <= rt_data_d;
      rf.rs_busy <= rs_busy_d;
      rf.rt_busy <= rt_busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_rd.sv
// tb/tb_regfile_rd.sv - directed vector table plus randomized model comparison for regfile_rd
module tb_regfile_rd;
  import cpu_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  regfile_rd_if bus ();

  regfile_rd dut (
    .CLK (CLK),
    .RST (RST),
    .rf  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic      rst;
    logic      rd;
    reg_addr_t rs;
    reg_addr_t rt;
    logic      iss;
    reg_addr_t ia;
    logic      wr;
    reg_addr_t wa;
    reg_data_t wd;
    reg_data_t ers;
    reg_data_t ert;
    logic      ebs;
    logic      ebt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic rst, rd, input int rs, rt, input logic iss, input int ia,
                             input logic wr, input int wa, input reg_data_t wd,
                             input reg_data_t ers, ert, input logic ebs, ebt);
    vec_t r;
    r.rst = rst; r.rd = rd; r.rs = reg_addr_t'(rs); r.rt = reg_addr_t'(rt);
    r.iss = iss; r.ia = reg_addr_t'(ia); r.wr = wr; r.wa = reg_addr_t'(wa); r.wd = wd;
    r.ers = ers; r.ert = ert; r.ebs = ebs; r.ebt = ebt;
    return r;
  endfunction

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, rd, input reg_addr_t rs, rt, input logic iss,
                       input reg_addr_t ia, input logic wr, input reg_addr_t wa, input reg_data_t wd);
    RST = rst; bus.rd_en = rd; bus.rs_addr = rs; bus.rt_addr = rt;
    bus.iss_en = iss; bus.iss_addr = ia; bus.wr_en = wr; bus.wr_addr = wa; bus.wr_data = wd;
  endtask

  // Reference state: architectural contents and pending-producer flags.
  reg_data_t m_mem  [NREG];
  bit        m_busy [NREG];
  reg_data_t m_rs, m_rt;
  bit        m_bs, m_bt;

  function automatic reg_data_t ref_data(input reg_addr_t a, input logic wr, input reg_addr_t wa,
                                         input reg_data_t wd);
    if (a == 0) return '0;
    if (BYP && wr && wa == a) return wd;
    return m_mem[a];
  endfunction

  function automatic bit ref_busy(input reg_addr_t a, input logic iss, input reg_addr_t ia,
                                  input logic wr, input reg_addr_t wa);
    if (a == 0) return 1'b0;
    if (iss && ia == a) return 1'b1;
    if (BYP && wr && wa == a) return 1'b0;
    return m_busy[a];
  endfunction

  initial begin
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);

    // Directed vectors: each row is one clock; expected outputs are sampled after that edge.
    tbl.push_back(v(1,1, 3,0, 0,0, 1,3,16'h1111, 16'h0000,16'h0000,0,0));
    tbl.push_back(v(1,1, 0,0, 0,0, 1,4,16'h2222, 16'h0000,16'h0000,0,0));
    for (int i = 0; i < NREG; i++)
      tbl.push_back(v(0,1, i,NREG-1-i, 0,0, 0,0,16'h0, 16'h0000,16'h0000,0,0));
    tbl.push_back(v(0,0, 3,0, 0,0, 1,3,16'hA5A5, 16'h0000,16'h0000,0,0));
    tbl.push_back(v(0,1, 3,0, 0,0, 0,0,16'h0, 16'hA5A5,16'h0000,0,0));
    tbl.push_back(v(0,1, 5,5, 0,0, 1,5,16'h1234,
                    BYP ? 16'h1234 : 16'h0000, BYP ? 16'h1234 : 16'h0000, 0,0));
    tbl.push_back(v(0,1, 5,3, 0,0, 0,0,16'h0, 16'h1234,16'hA5A5,0,0));
    tbl.push_back(v(0,1, 0,0, 1,2, 0,0,16'h0, 16'h0000,16'h0000,0,0));
    tbl.push_back(v(0,1, 2,3, 0,0, 0,0,16'h0, 16'h0000,16'hA5A5,1,0));
    tbl.push_back(v(0,1, 0,0, 0,0, 1,2,16'h0042, 16'h0000,16'h0000,0,0));
    tbl.push_back(v(0,1, 2,2, 0,0, 0,0,16'h0, 16'h0042,16'h0042,0,0));
    tbl.push_back(v(0,1, 3,3, 0,0, 0,0,16'h0, 16'hA5A5,16'hA5A5,0,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(0,0, 1,2, 0,0, 1,3,16'hFFFF, 16'hA5A5,16'hA5A5,0,0));
    tbl.push_back(v(0,1, 3,2, 0,0, 0,0,16'h0, 16'hFFFF,16'h0042,0,0));
    tbl.push_back(v(0,1, 0,0, 1,0, 1,0,16'hDEAD, 16'h0000,16'h0000,0,0));
    tbl.push_back(v(0,1, 0,0, 0,0, 0,0,16'h0, 16'h0000,16'h0000,0,0));
    tbl.push_back(v(0,1, 1,1, 1,4, 1,4,16'h7777, 16'h0000,16'h0000,0,0));
    tbl.push_back(v(0,1, 4,4, 0,0, 0,0,16'h0, 16'h7777,16'h7777,1,1));
    tbl.push_back(v(0,1, 4,1, 0,0, 1,4,16'h8888,
                    BYP ? 16'h8888 : 16'h7777, 16'h0000, !BYP, 0));
    tbl.push_back(v(0,1, 4,4, 0,0, 0,0,16'h0, 16'h8888,16'h8888,0,0));
    tbl.push_back(v(1,0, 4,4, 0,0, 0,0,16'h0, 16'h0000,16'h0000,0,0));
    tbl.push_back(v(0,1, 3,4, 0,0, 0,0,16'h0, 16'h0000,16'h0000,0,0));

    @(negedge CLK);
    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].rd, tbl[k].rs, tbl[k].rt, tbl[k].iss, tbl[k].ia,
            tbl[k].wr, tbl[k].wa, tbl[k].wd);
      @(posedge CLK);
      #1;
      check($sformatf("vec%0d rs_data", k), bus.rs_data, tbl[k].ers);
      check($sformatf("vec%0d rt_data", k), bus.rt_data, tbl[k].ert);
      check($sformatf("vec%0d rs_busy", k), {15'b0, bus.rs_busy}, {15'b0, tbl[k].ebs});
      check($sformatf("vec%0d rt_busy", k), {15'b0, bus.rt_busy}, {15'b0, tbl[k].ebt});
    end

    // Randomized traffic against the reference model, starting from a reset.
    for (int c = 0; c < 500; c++) begin
      logic      rst, rd, iss, wr;
      reg_addr_t rs, rt, ia, wa;
      reg_data_t wd;
      rst = (c == 0) || ($urandom_range(0, 49) == 0);
      rd  = ($urandom_range(0, 3) != 0);
      rs  = reg_addr_t'($urandom_range(0, NREG-1));
      rt  = ($urandom_range(0, 4) == 0) ? rs : reg_addr_t'($urandom_range(0, NREG-1));
      iss = ($urandom_range(0, 2) == 0);
      ia  = reg_addr_t'($urandom_range(0, NREG-1));
      wr  = ($urandom_range(0, 1) == 0);
      wa  = ($urandom_range(0, 2) == 0) ? rs : reg_addr_t'($urandom_range(0, NREG-1));
      wd  = reg_data_t'($urandom);
      drive(rst, rd, rs, rt, iss, ia, wr, wa, wd);

      if (rst) begin
        for (int r = 0; r < NREG; r++) begin
          m_mem[r]  = '0;
          m_busy[r] = 1'b0;
        end
        m_rs = '0; m_rt = '0; m_bs = 1'b0; m_bt = 1'b0;
      end else begin
        if (rd) begin
          m_rs = ref_data(rs, wr, wa, wd);
          m_rt = ref_data(rt, wr, wa, wd);
          m_bs = ref_busy(rs, iss, ia, wr, wa);
          m_bt = ref_busy(rt, iss, ia, wr, wa);
        end
        if (wr && wa != 0) m_mem[wa] = wd;
        if (wr) m_busy[wa] = 1'b0;
        if (iss && ia != 0) m_busy[ia] = 1'b1;
      end

      @(posedge CLK);
      #1;
      check($sformatf("rnd%0d rs_data", c), bus.rs_data, m_rs);
      check($sformatf("rnd%0d rt_data", c), bus.rt_data, m_rt);
      check($sformatf("rnd%0d rs_busy", c), {15'b0, bus.rs_busy}, {15'b0, m_bs});
      check($sformatf("rnd%0d rt_busy", c), {15'b0, bus.rt_busy}, {15'b0, m_bt});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
